// File: rtl/asmd_decimator.sv
// rtl/asmd_decimator.sv - frame-sum decimator: sums DEC accepted samples and publishes each frame sum on R0
module asmd_decimator #(
    parameter int DEC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  Data,
    input  logic        En,
    input  logic        Ld,
    output logic [15:0] R0
);

    localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEC - 1);

    typedef enum logic {
        S_IDLE,
        S_ACC
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    r0_q, r0_d;
    logic [15:0]    sum;

    assign sum = acc_q + {8'h00, Data};
    assign R0  = r0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= '0;
            r0_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r0_q    <= r0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r0_d    = r0_q;
        if (Ld) begin
            // Restart discards the partial frame; the last published sum stays visible.
            state_d = S_IDLE;
            acc_d   = 16'h0000;
            cnt_d   = '0;
        end else if (En) begin
            case (state_q)
                S_IDLE: begin
                    acc_d   = {8'h00, Data};
                    cnt_d   = CW'(1);
                    state_d = S_ACC;
                end
                S_ACC: begin
                    if (cnt_q == CNT_LAST) begin
                        r0_d    = sum;
                        acc_d   = 16'h0000;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asmd_decimator.sv
// tb/tb_asmd_decimator.sv - directed bench for asmd_decimator with DEC=4 and DEC=256 instances
module tb_asmd_decimator;

    logic        clk;
    logic        rst;
    logic [7:0]  data_a, data_b;
    logic        en_a, en_b;
    logic        ld_a, ld_b;
    logic [15:0] r0_a, r0_b;

    int checks = 0;
    int errors = 0;

    asmd_decimator #(.DEC(4)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .Data (data_a),
        .En   (en_a),
        .Ld   (ld_a),
        .R0   (r0_a)
    );

    asmd_decimator #(.DEC(256)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .Data (data_b),
        .En   (en_b),
        .Ld   (ld_b),
        .R0   (r0_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc_a(input logic en, input logic ld, input logic [7:0] d);
        en_a   = en;
        ld_a   = ld;
        data_a = d;
        @(posedge clk);
        #1;
        en_a   = 1'b0;
        ld_a   = 1'b0;
        data_a = 8'hxx;
    endtask

    task automatic chk_a(input string name, input logic [15:0] exp);
        checks++;
        if (r0_a !== exp) begin
            errors++;
            $display("FAIL %s: R0=%h expected %h", name, r0_a, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en_a = 1'b0; ld_a = 1'b0; data_a = 8'hxx;
        en_b = 1'b0; ld_b = 1'b0; data_b = 8'hxx;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_a("reset_r0_a", 16'h0000);
        checks++;
        if (r0_b !== 16'h0000) begin
            errors++;
            $display("FAIL reset_r0_b: R0=%h expected 0000", r0_b);
        end
        for (int i = 0; i < 3; i++) begin
            cyc_a(1'b0, 1'b0, 8'hxx);
            chk_a("reset_idle_hold", 16'h0000);
        end
    endtask

    task automatic test_steady;
        for (int i = 1; i <= 12; i++) begin
            cyc_a(1'b1, 1'b0, 8'h80);
            chk_a($sformatf("steady_%0d", i), (i < 4) ? 16'h0000 : 16'h0200);
        end
    endtask

    task automatic test_max;
        for (int i = 1; i <= 4; i++) begin
            cyc_a(1'b1, 1'b0, 8'hFF);
            chk_a($sformatf("max4_%0d", i), (i < 4) ? 16'h0200 : 16'h03FC);
        end
        for (int i = 1; i <= 256; i++) begin
            en_b = 1'b1;
            data_b = 8'hFF;
            @(posedge clk);
            #1;
            en_b = 1'b0;
            data_b = 8'hxx;
            if (i == 255 || i == 256) begin
                checks++;
                if (r0_b !== ((i == 256) ? 16'hFF00 : 16'h0000)) begin
                    errors++;
                    $display("FAIL max256_%0d: R0=%h expected %h", i, r0_b,
                             (i == 256) ? 16'hFF00 : 16'h0000);
                end
            end
        end
    endtask

    task automatic test_restart;
        cyc_a(1'b1, 1'b0, 8'h10);
        cyc_a(1'b1, 1'b0, 8'h10);
        cyc_a(1'b1, 1'b1, 8'h55);
        chk_a("restart_ld_hold", 16'h03FC);
        cyc_a(1'b1, 1'b0, 8'h01);
        cyc_a(1'b1, 1'b0, 8'h02);
        cyc_a(1'b1, 1'b0, 8'h03);
        chk_a("restart_3rd", 16'h03FC);
        cyc_a(1'b1, 1'b0, 8'h04);
        chk_a("restart_4th", 16'h000A);
    endtask

    task automatic test_pause;
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 8'h80);
        chk_a("pause_prelude", 16'h0200);
        cyc_a(1'b1, 1'b0, 8'h01);
        cyc_a(1'b1, 1'b0, 8'h02);
        for (int i = 0; i < 3; i++) begin
            cyc_a(1'b0, 1'b0, 8'hxx);
            chk_a("pause_hold", 16'h0200);
        end
        cyc_a(1'b1, 1'b0, 8'h03);
        chk_a("pause_3rd", 16'h0200);
        cyc_a(1'b1, 1'b0, 8'h04);
        chk_a("pause_4th", 16'h000A);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 8'h80);
        chk_a("rstmid_prelude", 16'h0200);
        cyc_a(1'b1, 1'b0, 8'h80);
        cyc_a(1'b1, 1'b0, 8'h80);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_a("rstmid_cleared", 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            cyc_a(1'b1, 1'b0, 8'h01);
            chk_a($sformatf("rstmid_%0d", i), (i < 4) ? 16'h0000 : 16'h0004);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 8; i++) begin
            cyc_a(1'b1, 1'b0, 8'(i));
            if (i == 4) chk_a("b2b_frame1", 16'h000A);
            if (i == 8) chk_a("b2b_frame2", 16'h001A);
        end
    endtask

    initial begin
        rst = 1'b0;
        en_a = 1'b0; ld_a = 1'b0; data_a = 8'h00;
        en_b = 1'b0; ld_b = 1'b0; data_b = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_steady();
        test_max();
        test_restart();
        test_pause();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
